pipe_mux_reg: RTL and testbench
===============================

Name: pipe_mux_reg

Overview:
- Parametrised N-way, WIDTH-bit registered multiplexer with a valid/ready handshake and a 2-entry skid buffer.
- Successor to the combinational 2:1 ALU-operand mux; used where a select stage sits between pipeline stages (forwarding/operand select, writeback source select) and must tolerate downstream stalls without losing data.
- Full throughput (1 beat/cycle) when the sink is always ready. Supports pipeline flush.

Parameters:
- WIDTH, 32, data width of each input and of the output
- N, 4, number of data inputs (legal: 2..16)
- SEL_W, $clog2(N), select width (derived; do not override)

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- FLUSH  in  1  synchronous clear of all buffered beats
- IN_DATA  in  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- SEL  in  SEL_W  binary select, sampled with IN_VALID
- IN_VALID  in  1  upstream beat present
- IN_READY  out  1  block can accept a beat this cycle
- OUT_DATA  out  WIDTH  selected data of the head beat
- OUT_SEL  out  SEL_W  select value that produced OUT_DATA
- OUT_VALID  out  1  head beat valid
- OUT_READY  in  1  downstream accepts head beat

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, IN_READY=1, both buffer entries empty. Deassertion is synchronised externally.
- Accept: a beat is taken on a rising edge when IN_VALID && IN_READY. Data = IN_DATA[SEL*WIDTH +: WIDTH], tagged with SEL.
- Out-of-range SEL (SEL >= N, only possible when N is not a power of 2): data = 0, beat still accepted.
- Output: a beat leaves on the edge where OUT_VALID && OUT_READY.
- Storage: main register (drives OUT_*) plus one skid register. State = EMPTY, ONE (main only), TWO (main + skid).
- EMPTY: on accept go to ONE.
- ONE, accept only: go to TWO if the output did not pop; if it popped, the new beat replaces main and the state stays ONE.
- ONE, pop only: go to EMPTY.
- TWO: the skid beat moves to main on pop (state goes to ONE). No accept is possible in TWO.
- IN_READY is registered: IN_READY = (state != TWO). It does not depend combinationally on OUT_READY.
- Latency: an accepted beat appears on OUT_* the cycle after acceptance when the block is empty. Ordering is strictly FIFO.
- OUT_DATA and OUT_SEL are stable while OUT_VALID && !OUT_READY. They hold their last value when OUT_VALID=0 (value unspecified after a flush).
- FLUSH: at the next edge the state becomes EMPTY and OUT_VALID=0, IN_READY=1. A beat presented in the FLUSH cycle is dropped. A pop in that cycle still counts as completed downstream. FLUSH has priority over accept and pop.
- Simultaneous accept+pop in ONE: no bubble; throughput is 1/cycle.
- Reset mid-operation: all buffered beats are discarded immediately.

Optional Feature:
- Macro PIPE_MUX_SEL_CHECK_EN.
- When defined, adds output SEL_ERR (1 bit, reset 0). It is sticky-set when a beat is accepted with SEL >= N, and cleared only by RST_N or FLUSH. Illegal-select beats still pass with zero data.
- When undefined, the port is absent and out-of-range selects silently yield zero data.

Test Plan:
- Reset: hold RST_N=0, then release -> OUT_VALID=0, OUT_DATA=0, IN_READY=1. Assert RST_N low asynchronously mid-cycle with 2 beats buffered -> OUT_VALID falls without waiting for a CLK edge.
- Streaming: N=4, inputs 0x11,0x22,0x33,0x44, OUT_READY=1, SEL=0,1,2,3 on consecutive cycles -> OUT_DATA 0x11,0x22,0x33,0x44 on cycles 1..4, OUT_SEL 0..3, no bubbles.
- Backpressure: OUT_READY=0, push SEL=2 then SEL=3 -> IN_READY=0 after the second beat. OUT_DATA holds 0x33. Raise OUT_READY -> 0x33 then 0x44 emitted; IN_READY=1 again one cycle after the first pop.
- Flush: 2 beats buffered plus FLUSH=1 with IN_VALID=1 (SEL=1) -> next cycle OUT_VALID=0, IN_READY=1, and 0x22 never appears.
- Illegal select: N=3, SEL=3 accepted -> OUT_DATA=0. With PIPE_MUX_SEL_CHECK_EN, SEL_ERR=1 and stays 1 until FLUSH.
- Random: random IN_VALID/OUT_READY/SEL for 10k cycles against a scoreboard -> no loss, duplication or reordering. OUT_* stable while stalled.

Source files
------------

// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N-way registered select stage with valid/ready handshake and 2-entry skid buffer
//
// Purpose:
//   Selects one of N WIDTH-bit inputs with a binary select and registers the
//   result together with its select tag. A main register drives the outputs;
//   a skid register absorbs one extra beat so that the upstream ready can be
//   a flop output, independent of the downstream ready. Strict FIFO order,
//   one beat per cycle when the sink never stalls, synchronous flush.
//
// Optional feature (macro PIPE_MUX_SEL_CHECK_EN):
//   Adds o_sel_err, a sticky flag set when a beat is accepted with a select
//   value >= N. Cleared by reset or flush. Without the macro the port is
//   absent and out-of-range selects simply yield zero data.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous clear of all buffered beats (beats in flight dropped)
//   i_in_data    flattened inputs, input k at [k*WIDTH +: WIDTH]
//   i_sel        binary select, sampled with i_in_valid
//   i_in_valid   upstream beat present
//   o_in_ready   block can accept a beat this cycle (registered)
//   o_out_data   selected data of the head beat
//   o_out_sel    select value that produced o_out_data
//   o_out_valid  head beat valid
//   i_out_ready  downstream accepts head beat
//   o_sel_err    sticky illegal-select flag (PIPE_MUX_SEL_CHECK_EN only)

module pipe_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic [N*WIDTH-1:0]   i_in_data,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic [SEL_W-1:0]     o_out_sel,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
`ifdef PIPE_MUX_SEL_CHECK_EN
  ,
  output logic                 o_sel_err
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_in_ready;
  logic [WIDTH-1:0]   r_main_data;
  logic [SEL_W-1:0]   r_main_sel;
  logic [WIDTH-1:0]   r_skid_data;
  logic [SEL_W-1:0]   r_skid_sel;

  logic [WIDTH-1:0]   w_mux_data;
  logic               w_accept;
  logic               w_pop;
  logic               w_main_ld;
  logic               w_main_from_skid;
  logic               w_skid_ld;

  // Decode by comparison against each legal index so an out-of-range select
  // falls through to zero without a variable part-select running off the bus.
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_mux_data = i_in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_out_valid = (r_state != ST_EMPTY);
  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_main_data;
  assign o_out_sel   = r_main_sel;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_pop    = o_out_valid && i_out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    if (i_flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_ONE;
            w_main_ld    = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            // Head leaves and the new beat takes its place: no bubble.
            w_main_ld = 1'b1;
          end else if (w_accept) begin
            w_next_state = ST_TWO;
            w_skid_ld    = 1'b1;
          end else if (w_pop) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // r_in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_next_state     = ST_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else begin
      r_state    <= w_next_state;
      // Ready is the registered image of "next state is not full".
      r_in_ready <= (w_next_state != ST_TWO);
      if (w_main_ld) begin
        r_main_data <= w_mux_data;
        r_main_sel  <= i_sel;
      end else if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_sel  <= r_skid_sel;
      end
      if (w_skid_ld) begin
        r_skid_data <= w_mux_data;
        r_skid_sel  <= i_sel;
      end
    end
  end

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic w_sel_ok;
  logic r_sel_err;

  always_comb begin
    w_sel_ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_sel_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_err <= 1'b0;
    end else if (i_flush) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end

  assign o_sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb/tb_pipe_mux_reg.sv - self-checking bench for pipe_mux_reg (N=4 and N=3 instances)

module tb_pipe_mux_reg;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=32, N=4
  logic [31:0]  a_words [4];
  logic [127:0] a_in_data;
  logic         a_flush, a_in_valid, a_out_ready;
  logic [1:0]   a_sel;
  logic         a_in_ready, a_out_valid;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_sel;

  // Instance B: WIDTH=8, N=3 (select value 3 is illegal)
  logic [7:0]   b_words [3];
  logic [23:0]  b_in_data;
  logic         b_flush, b_in_valid, b_out_ready;
  logic [1:0]   b_sel;
  logic         b_in_ready, b_out_valid;
  logic [7:0]   b_out_data;
  logic [1:0]   b_out_sel;
`ifdef PIPE_MUX_SEL_CHECK_EN
  logic         a_sel_err, b_sel_err;
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) a_in_data[k*32 +: 32] = a_words[k];
    for (int k = 0; k < 3; k++) b_in_data[k*8 +: 8] = b_words[k];
  end

  pipe_mux_reg #(.WIDTH(32), .N(4)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(a_flush), .i_in_data(a_in_data),
    .i_sel(a_sel), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .o_out_data(a_out_data), .o_out_sel(a_out_sel), .o_out_valid(a_out_valid),
    .i_out_ready(a_out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
    , .o_sel_err(a_sel_err)
`endif
  );

  pipe_mux_reg #(.WIDTH(8), .N(3)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(b_flush), .i_in_data(b_in_data),
    .i_sel(b_sel), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .o_out_data(b_out_data), .o_out_sel(b_out_sel), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready)
`ifdef PIPE_MUX_SEL_CHECK_EN
    , .o_sel_err(b_sel_err)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for A: an in-order queue holding at most two beats.
  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } beat_t;
  beat_t q[$];

  task automatic check_a();
    chk("a_in_ready", {31'd0, a_in_ready}, {31'd0, q.size() < 2});
    chk("a_out_valid", {31'd0, a_out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("a_out_data", a_out_data, q[0].data);
      chk("a_out_sel", {30'd0, a_out_sel}, {30'd0, q[0].sel});
    end
  endtask

  // One clock of instance A: predict from the pre-edge view, then compare.
  task automatic step_a();
    bit    acc, pop;
    beat_t nb;
    acc     = a_in_valid && (q.size() < 2);
    pop     = a_out_ready && (q.size() != 0);
    nb.sel  = a_sel;
    nb.data = a_words[a_sel];
    @(posedge clk);
    #1;
    if (a_flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(nb);
    end
    check_a();
  endtask

  task automatic set_words(input logic [31:0] w0, w1, w2, w3);
    a_words[0] = w0; a_words[1] = w1; a_words[2] = w2; a_words[3] = w3;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_sel = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_sel = 0;
    set_words(32'h11, 32'h22, 32'h33, 32'h44);
    b_words[0] = 8'hA1; b_words[1] = 8'hB2; b_words[2] = 8'hC3;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    chk("rst_out_sel", {30'd0, a_out_sel}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, sink always ready
    a_out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      a_in_valid = 1; a_sel = 2'(s);
      step_a();
      chk("stream_data", a_out_data, 32'h11 * (s + 1));
      chk("stream_valid", {31'd0, a_out_valid}, 32'd1);
    end
    a_in_valid = 0;
    step_a();
    chk("stream_drain", {31'd0, a_out_valid}, 32'd0);

    // Backpressure
    a_out_ready = 0;
    a_in_valid = 1; a_sel = 2; step_a();
    a_sel = 3; step_a();
    chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    a_in_valid = 0; step_a();
    chk("bp_hold", a_out_data, 32'h33);
    a_out_ready = 1; step_a();
    chk("bp_second", a_out_data, 32'h44);
    chk("bp_ready_back", {31'd0, a_in_ready}, 32'd1);
    step_a();
    chk("bp_empty", {31'd0, a_out_valid}, 32'd0);

    // Flush with two beats buffered and a beat offered
    a_out_ready = 0;
    a_in_valid = 1; a_sel = 2; step_a();
    a_sel = 3; step_a();
    a_flush = 1; a_sel = 1; step_a();
    a_flush = 0; a_in_valid = 0;
    chk("flush_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush_ready", {31'd0, a_in_ready}, 32'd1);
    // Flush with one beat buffered and room for the offered beat
    a_in_valid = 1; a_sel = 0; step_a();
    a_flush = 1; a_sel = 1; step_a();
    a_flush = 0; a_in_valid = 0;
    a_out_ready = 1; step_a();
    chk("flush_drop", {31'd0, a_out_valid}, 32'd0);

    // Asynchronous reset with two beats buffered
    a_out_ready = 0;
    a_in_valid = 1; a_sel = 0; step_a();
    a_sel = 1; step_a();
    a_in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    chk("async_rst_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, a_in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step_a();

    // Illegal select on the N=3 instance
    b_out_ready = 1; b_in_valid = 1; b_sel = 3;
    @(posedge clk); #1;
    chk("illegal_data", {24'd0, b_out_data}, 32'd0);
    chk("illegal_sel", {30'd0, b_out_sel}, 32'd3);
    chk("illegal_valid", {31'd0, b_out_valid}, 32'd1);
`ifdef PIPE_MUX_SEL_CHECK_EN
    chk("sel_err_set", {31'd0, b_sel_err}, 32'd1);
    chk("sel_err_a", {31'd0, a_sel_err}, 32'd0);
`endif
    b_sel = 1;
    @(posedge clk); #1;
    chk("legal_after", {24'd0, b_out_data}, 32'hB2);
`ifdef PIPE_MUX_SEL_CHECK_EN
    chk("sel_err_sticky", {31'd0, b_sel_err}, 32'd1);
`endif
    b_in_valid = 0; b_flush = 1;
    @(posedge clk); #1;
    b_flush = 0;
    chk("b_flush_valid", {31'd0, b_out_valid}, 32'd0);
`ifdef PIPE_MUX_SEL_CHECK_EN
    chk("sel_err_clear", {31'd0, b_sel_err}, 32'd0);
`endif
    b_in_valid = 1; b_sel = 2;
    @(posedge clk); #1;
    b_in_valid = 0;
    chk("b_sel2", {24'd0, b_out_data}, 32'hC3);
`ifdef PIPE_MUX_SEL_CHECK_EN
    chk("sel_err_stay0", {31'd0, b_sel_err}, 32'd0);
`endif

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      for (int k = 0; k < 4; k++) a_words[k] = $urandom;
      a_in_valid  = ($urandom_range(3) != 0);
      a_out_ready = ($urandom_range(2) != 0);
      a_sel       = 2'($urandom_range(3));
      a_flush     = ($urandom_range(63) == 0);
      step_a();
    end
    a_flush = 0; a_in_valid = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
